// File: rtl/gray_decode_ctrl.sv
// rtl/gray_decode_ctrl.sv - bit-serial Gray-to-binary decoder, one bit per cycle MSB first; optional macro GRAY_DECODE_CTRL_DELTA_EN adds out_delta
module gray_decode_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef GRAY_DECODE_CTRL_DELTA_EN
    ,
    output logic [WIDTH-1:0] out_delta
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] gray;
    logic [CW-1:0]    cnt;
    logic             run;
    logic             bit_now;
    logic [WIDTH-1:0] data_next;
`ifdef GRAY_DECODE_CTRL_DELTA_EN
    logic [WIDTH-1:0] prev;
`endif

    // Decoded bit for the current position, and the output word with that bit merged in
    always_comb begin
        bit_now        = run ^ gray[cnt];
        data_next      = out_data;
        data_next[cnt] = bit_now;
    end

    // Control FSM with registered handshake/status outputs; unprocessed out_data bits keep old values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            gray      <= '0;
            cnt       <= '0;
            run       <= 1'b0;
`ifdef GRAY_DECODE_CTRL_DELTA_EN
            prev      <= '0;
            out_delta <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        gray     <= in_data;
                        cnt      <= CW'(WIDTH - 1);
                        run      <= 1'b0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    out_data <= data_next;
                    run      <= bit_now;
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
`ifdef GRAY_DECODE_CTRL_DELTA_EN
                        out_delta <= data_next - prev;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
`ifdef GRAY_DECODE_CTRL_DELTA_EN
                        prev      <= out_data;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_decode_ctrl.sv
// tb/tb_gray_decode_ctrl.sv - self-checking bench for gray_decode_ctrl (delta checks when GRAY_DECODE_CTRL_DELTA_EN is defined)
module tb_gray_decode_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] out_data;
`ifdef GRAY_DECODE_CTRL_DELTA_EN
    logic [W-1:0] out_delta;
    logic [W-1:0] model_prev = '0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gray_decode_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef GRAY_DECODE_CTRL_DELTA_EN
        ,
        .out_delta (out_delta)
`endif
    );

    // Reference: each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word after 'gap' idle cycles, then check latency, busy/in_ready and result
    task automatic send(input logic [W-1:0] g, input int gap);
        int lat;
        bit ok;
        int n;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = g;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        lat = 0;
        ok  = 1'b1;
        while (out_valid !== 1'b1 && lat < 3 * W) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            tick();
            lat++;
        end
        chk("shift_in_ready_low_busy", ok, 1);
        chk("latency", lat, W);
        chk("out_data", out_data, gray2bin(g));
`ifdef GRAY_DECODE_CTRL_DELTA_EN
        chk("out_delta", out_delta, W'(gray2bin(g) - model_prev));
`endif
    endtask

    // Hold out_ready low for 'hold' cycles with noise on in_valid, then accept the word
    task automatic recv(input logic [W-1:0] exp, input int hold);
        bit ok;
`ifdef GRAY_DECODE_CTRL_DELTA_EN
        logic [W-1:0] d0;
        d0 = out_delta;
`endif
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = W'($urandom);
            tick();
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
`ifdef GRAY_DECODE_CTRL_DELTA_EN
            if (out_delta !== d0) ok = 1'b0;
`endif
        end
        if (hold > 0) chk("done_hold", ok, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_busy", busy, 0);
`ifdef GRAY_DECODE_CTRL_DELTA_EN
        model_prev = exp;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_out_data"}, out_data, 0);
`ifdef GRAY_DECODE_CTRL_DELTA_EN
        chk({tag, "_out_delta"}, out_delta, 0);
`endif
    endtask

    initial begin
        logic [W-1:0] g;
        bit seen;

        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        send(16'h8000, 0);
        chk("msb_only_word", out_data, 16'hFFFF);
        recv(16'hFFFF, 0);

        send(16'h0001, 0);
        chk("seq_w0", out_data, 16'h0001);
        recv(16'h0001, 0);
        send(16'h0003, 0);
        chk("seq_w1", out_data, 16'h0002);
        recv(16'h0002, 1);
        send(16'h1B2E, 2);
        chk("seq_w2", out_data, 16'h1234);
        recv(16'h1234, 0);

        send(16'h1B2E, 0);
        recv(16'h1234, 5);

        in_valid = 1'b1;
        in_data  = 16'h1B2E;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midshift_reset");
        tick();
        rst_n = 1'b1;
`ifdef GRAY_DECODE_CTRL_DELTA_EN
        model_prev = '0;
`endif
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("no_valid_after_reset", seen, 0);
        send(16'h0003, 0);
        chk("after_reset_word", out_data, 16'h0002);
        recv(16'h0002, 0);

`ifdef GRAY_DECODE_CTRL_DELTA_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_prev = '0;
        send(16'h0001, 0);
        chk("delta0", out_delta, 16'h0001);
        recv(16'h0001, 0);
        send(16'h0003, 0);
        chk("delta1", out_delta, 16'h0001);
        recv(16'h0002, 0);
        send(16'h0000, 0);
        chk("delta2", out_delta, 16'hFFFE);
        recv(16'h0000, 0);
`endif

        for (int i = 0; i < 1000; i++) begin
            g = W'($urandom);
            send(g, int'($urandom_range(0, 3)));
            recv(gray2bin(g), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
